// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised asynchronous serial transmitter.
// Accepts a parallel word over a Send/Ready handshake and sends it on SDout
// as start bit, DATA_W data bits, optional parity bit and 1 or 2 stop bits.
// Each bit lasts CLKS_PER_BIT clock cycles. SDout and the status outputs
// are registered, so the line never glitches between bits.
module uart_tx_param #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int MSB_FIRST    = 0
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Send,
    input  logic [DATA_W-1:0] PDin,
    input  logic [1:0]        Par_mode,
    output logic              Ready,
    output logic              Busy,
    output logic              Done,
    output logic              SCout,
    output logic              SDout
);

    localparam int CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W   = $clog2(DATA_W);
    localparam int OUT_POS = (MSB_FIRST != 0) ? DATA_W - 1 : 0;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity bit for the latched word: even -> XOR of data, odd -> inverse.
    function automatic logic parity_calc(input logic [DATA_W-1:0] word,
                                         input logic [1:0]        mode);
        logic par;
        case (mode)
            2'b01:   par = ^word;
            2'b10:   par = ~(^word);
            default: par = 1'b0;
        endcase
        return par;
    endfunction

    // A parity slot exists only for even (01) and odd (10); 00 and 11 skip it.
    function automatic logic parity_enabled(input logic [1:0] mode);
        logic en;
        case (mode)
            2'b01:   en = 1'b1;
            2'b10:   en = 1'b1;
            default: en = 1'b0;
        endcase
        return en;
    endfunction

    // Move the next data bit into the output position (OUT_POS).
    function automatic logic [DATA_W-1:0] shift_step(input logic [DATA_W-1:0] word);
        logic [DATA_W-1:0] res;
        if (MSB_FIRST != 0) begin
            res = {word[DATA_W-2:0], 1'b0};
        end else begin
            res = {1'b0, word[DATA_W-1:1]};
        end
        return res;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  baud_cnt_r;
    logic [IDX_W-1:0]  bit_idx_r;
    logic [DATA_W-1:0] shift_r;
    logic [DATA_W-1:0] shift_nxt_s;
    logic              par_bit_r;
    logic              par_en_r;
    logic              sdout_r;
    logic              ready_r;
    logic              busy_r;
    logic              done_r;
    logic              sdout_nxt_s;
    logic              ready_nxt_s;
    logic              busy_nxt_s;
    logic              done_nxt_s;
    logic              bit_end_s;
    logic              accept_s;

    assign bit_end_s = (baud_cnt_r == BAUD_LAST);
    assign accept_s  = (state_r == ST_IDLE) && Send && ready_r;

    // State register and registered outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r <= ST_IDLE;
            sdout_r <= 1'b1;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            sdout_r <= sdout_nxt_s;
            ready_r <= ready_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Next-state logic: every non-idle state advances on the last baud cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s && (bit_idx_r == DATA_LAST)) begin
                    state_nxt_s = par_en_r ? ST_PARITY : ST_STOP;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_end_s && (bit_idx_r == STOP_LAST)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next shift-register content: load on accept, shift after each data bit.
    always_comb begin
        shift_nxt_s = shift_r;
        if (accept_s) begin
            shift_nxt_s = PDin;
        end else if ((state_r == ST_DATA) && bit_end_s) begin
            shift_nxt_s = shift_step(shift_r);
        end else begin
            shift_nxt_s = shift_r;
        end
    end

    // Output logic: next values for the registered line and status outputs.
    always_comb begin
        sdout_nxt_s = 1'b1;
        case (state_nxt_s)
            ST_IDLE:   sdout_nxt_s = 1'b1;
            ST_START:  sdout_nxt_s = 1'b0;
            ST_DATA:   sdout_nxt_s = shift_nxt_s[OUT_POS];
            ST_PARITY: sdout_nxt_s = par_bit_r;
            ST_STOP:   sdout_nxt_s = 1'b1;
            default:   sdout_nxt_s = 1'b1;
        endcase
        ready_nxt_s = (state_nxt_s == ST_IDLE);
        busy_nxt_s  = (state_nxt_s != ST_IDLE);
        done_nxt_s  = (state_r == ST_STOP) && (state_nxt_s == ST_IDLE);
    end

    // Datapath: baud counter, bit index, shift register and latched parity.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            baud_cnt_r <= '0;
            bit_idx_r  <= '0;
            shift_r    <= '0;
            par_bit_r  <= 1'b0;
            par_en_r   <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) || bit_end_s) begin
                baud_cnt_r <= '0;
            end else begin
                baud_cnt_r <= baud_cnt_r + CNT_W'(1);
            end
            if (state_nxt_s != state_r) begin
                bit_idx_r <= '0;
            end else if (bit_end_s) begin
                bit_idx_r <= bit_idx_r + IDX_W'(1);
            end else begin
                bit_idx_r <= bit_idx_r;
            end
            shift_r <= shift_nxt_s;
            if (accept_s) begin
                par_bit_r <= parity_calc(PDin, Par_mode);
                par_en_r  <= parity_enabled(Par_mode);
            end else begin
                par_bit_r <= par_bit_r;
                par_en_r  <= par_en_r;
            end
        end
    end

    assign SCout = Clk;
    assign SDout = sdout_r;
    assign Ready = ready_r;
    assign Busy  = busy_r;
    assign Done  = done_r;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four instances cover even/odd/none
// parity, 1 and 2 stop bits, MSB-first order and CLKS_PER_BIT=1. Expected
// frames are written out by hand as bit strings (start bit first).
module tb_uart_tx_param;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       send_v = 4'b0000;
    logic [3:0][15:0] pdin_v = '0;
    logic [3:0][1:0]  mode_v = '0;
    logic [3:0]       ready_v, busy_v, done_v, scout_v, sdout_v;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    // a: 8 bits, 4 clk/bit, 1 stop, LSB first
    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .MSB_FIRST(0)) u_dut_a (
        .Clk(clk), .Rst_n(rst_n), .Send(send_v[0]), .PDin(pdin_v[0][7:0]), .Par_mode(mode_v[0]),
        .Ready(ready_v[0]), .Busy(busy_v[0]), .Done(done_v[0]), .SCout(scout_v[0]), .SDout(sdout_v[0]));
    // b: 2 stop bits
    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(2), .MSB_FIRST(0)) u_dut_b (
        .Clk(clk), .Rst_n(rst_n), .Send(send_v[1]), .PDin(pdin_v[1][7:0]), .Par_mode(mode_v[1]),
        .Ready(ready_v[1]), .Busy(busy_v[1]), .Done(done_v[1]), .SCout(scout_v[1]), .SDout(sdout_v[1]));
    // c: MSB first
    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .MSB_FIRST(1)) u_dut_c (
        .Clk(clk), .Rst_n(rst_n), .Send(send_v[2]), .PDin(pdin_v[2][7:0]), .Par_mode(mode_v[2]),
        .Ready(ready_v[2]), .Busy(busy_v[2]), .Done(done_v[2]), .SCout(scout_v[2]), .SDout(sdout_v[2]));
    // d: 5 bits, 1 clk/bit
    uart_tx_param #(.DATA_W(5), .CLKS_PER_BIT(1), .STOP_BITS(1), .MSB_FIRST(0)) u_dut_d (
        .Clk(clk), .Rst_n(rst_n), .Send(send_v[3]), .PDin(pdin_v[3][4:0]), .Par_mode(mode_v[3]),
        .Ready(ready_v[3]), .Busy(busy_v[3]), .Done(done_v[3]), .SCout(scout_v[3]), .SDout(sdout_v[3]));

    // Single comparison point: counts every vector, reports miscompares.
    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Sends one word on instance k and checks SDout every cycle against seq.
    task automatic send_frame(input int k, input logic [15:0] d, input logic [1:0] m,
                              input int cpb, input string seq, input string tag);
        int  nb;
        logic exp_bit;
        nb = seq.len();
        @(negedge clk);
        check_vec({tag, "_ready_pre"}, ready_v[k], 1);
        send_v[k] = 1'b1;
        pdin_v[k] = d;
        mode_v[k] = m;
        @(posedge clk);
        #1;
        send_v[k] = 1'b0;
        pdin_v[k] = ~d;
        mode_v[k] = ~m;
        for (int j = 0; j < nb * cpb; j++) begin
            @(negedge clk);
            exp_bit = (seq.getc(j / cpb) == 8'h31);
            check_vec({tag, "_sdout"}, sdout_v[k], exp_bit);
            check_vec({tag, "_busy"}, busy_v[k], 1);
            check_vec({tag, "_ready"}, ready_v[k], 0);
            check_vec({tag, "_done_early"}, done_v[k], 0);
        end
        @(negedge clk);
        check_vec({tag, "_done"}, done_v[k], 1);
        check_vec({tag, "_ready_end"}, ready_v[k], 1);
        check_vec({tag, "_busy_end"}, busy_v[k], 0);
        check_vec({tag, "_idle_line"}, sdout_v[k], 1);
        @(negedge clk);
        check_vec({tag, "_done_pulse"}, done_v[k], 0);
    endtask

    function automatic logic [7:0] hs_word(input int n);
        return 8'(n * 29 + 7);
    endfunction

    initial begin
        int       e, r, fr, bi;
        logic [7:0] w;
        logic     exp_sd;

        // Reset state
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check_vec("rst_sdout", sdout_v[k], 1);
            check_vec("rst_ready", ready_v[k], 1);
            check_vec("rst_busy", busy_v[k], 0);
            check_vec("rst_done", done_v[k], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_vec("scout_low", scout_v[0], 0);
        @(posedge clk);
        #1;
        check_vec("scout_high", scout_v[0], 1);

        // A5 even parity, LSB first: 44 cycles
        send_frame(0, 16'h00A5, 2'b01, 4, "01010010101", "even_a5");
        // A5 with reserved mode 11: no parity slot, 40 cycles
        send_frame(0, 16'h00A5, 2'b11, 4, "0101001011", "mode11_a5");
        // A5 odd parity, two stop bits: 48 cycles
        send_frame(1, 16'h00A5, 2'b10, 4, "010100101111", "odd_2stop");
        // 80 MSB first, no parity: 40 cycles
        send_frame(2, 16'h0080, 2'b00, 4, "0100000001", "msb_80");
        // 5'b10011, even parity, 1 clk/bit: 8 cycles
        send_frame(3, 16'h0013, 2'b01, 1, "01100111", "cpb1_13");

        // Send held high, PDin changing every cycle: accepts at edges 0, 41, 82
        @(negedge clk);
        for (int n = 0; n <= 123; n++) begin
            if (n > 0) begin
                e  = n - 1;
                r  = e % 41;
                fr = e / 41;
                w  = hs_word(41 * fr);
                bi = r / 4;
                if (r == 40) exp_sd = 1'b1;
                else if (bi == 0) exp_sd = 1'b0;
                else if (bi <= 8) exp_sd = w[bi-1];
                else exp_sd = 1'b1;
                check_vec("hs_sdout", sdout_v[0], exp_sd);
                check_vec("hs_done", done_v[0], (r == 40) ? 1 : 0);
                check_vec("hs_ready", ready_v[0], (r == 40) ? 1 : 0);
            end
            if (n < 123) begin
                send_v[0] = 1'b1;
                pdin_v[0] = 16'(hs_word(n));
                mode_v[0] = 2'b00;
            end else begin
                send_v[0] = 1'b0;
            end
            @(negedge clk);
        end
        check_vec("hs_idle_after", ready_v[0], 1);

        // Reset during data bit 3 (edges 16..19 after accept)
        send_v[0] = 1'b1;
        pdin_v[0] = 16'h0000;
        mode_v[0] = 2'b00;
        @(posedge clk);
        #1;
        send_v[0] = 1'b0;
        repeat (17) @(negedge clk);
        check_vec("midrst_pre_sdout", sdout_v[0], 0);
        check_vec("midrst_pre_busy", busy_v[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_vec("midrst_sdout", sdout_v[0], 1);
        check_vec("midrst_ready", ready_v[0], 1);
        check_vec("midrst_busy", busy_v[0], 0);
        check_vec("midrst_done", done_v[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_vec("midrst_no_done", done_v[0], 0);
            check_vec("midrst_line_idle", sdout_v[0], 1);
        end
        // Clean frame after recovery: 3C even parity
        send_frame(0, 16'h003C, 2'b01, 4, "00011110001", "post_rst_3c");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
